alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue_if.sv | 31 +++
 rtl/alu_issue.sv | 107 ++++++++++
 tb/tb_alu_issue.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// alu_issue_if: instruction-in / ALU-op-out bundle for alu_issue
interface alu_issue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 5,
  parameter int SHAMT_WIDTH = 5
);
  logic in_valid, in_ready;
  logic [5:0] opcode, funct;
  logic [4:0] rs_addr, rt_addr;
  logic [DATA_WIDTH-1:0] rs_data, rt_data;
  logic [15:0] imm;
  logic [SHAMT_WIDTH-1:0] shamt_in;
  logic fwd_we;
  logic [4:0] fwd_addr;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic flush, out_ready, out_valid;
  logic [2*DATA_WIDTH-1:0] dataIn;
  logic [CTRL_WIDTH-1:0] ctrl;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic en_n, illegal;
  modport slave (
    input in_valid, opcode, funct, rs_addr, rt_addr, rs_data, rt_data, imm, shamt_in,
          fwd_we, fwd_addr, fwd_data, flush, out_ready,
    output in_ready, out_valid, dataIn, ctrl, shamt, en_n, illegal
  );
  modport master (
    output in_valid, opcode, funct, rs_addr, rt_addr, rs_data, rt_data, imm, shamt_in,
           fwd_we, fwd_addr, fwd_data, flush, out_ready,
    input in_ready, out_valid, dataIn, ctrl, shamt, en_n, illegal
  );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: MIPS ALU-op decode with writeback bypass and a two-entry (main + skid) issue buffer
module alu_issue #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 5,
  parameter int SHAMT_WIDTH = 5
) (
  input logic clk,
  input logic rst_n,
  alu_issue_if.slave bus
);
  typedef struct packed {
    logic [2*DATA_WIDTH-1:0] d;
    logic [CTRL_WIDTH-1:0] c;
    logic [SHAMT_WIDTH-1:0] s;
  } ent_t;
  logic [DATA_WIDTH-1:0] rs_v, rt_v, imm_x, b;
  logic [3:0] code;
  logic legal, shift, br, use_imm, sx;
  ent_t nxt, main_q, main_d, skid_q, skid_d;
  logic main_v_q, main_v_d, skid_v_q, skid_v_d, in_ready_q, illegal_q, acc, push, drain;
  assign rs_v = bus.rs_addr == 5'd0 ? '0 :
                (bus.fwd_we && bus.fwd_addr == bus.rs_addr) ? bus.fwd_data : bus.rs_data;
  assign rt_v = bus.rt_addr == 5'd0 ? '0 :
                (bus.fwd_we && bus.fwd_addr == bus.rt_addr) ? bus.fwd_data : bus.rt_data;
  always_comb begin
    legal = 1'b1;
    code = 4'd0;
    shift = 1'b0;
    br = 1'b0;
    use_imm = 1'b0;
    sx = 1'b0;
    case (bus.opcode)
      6'h00: case (bus.funct)
        6'h24: code = 4'd0;
        6'h25: code = 4'd1;
        6'h27: code = 4'd2;
        6'h26: code = 4'd3;
        6'h20, 6'h21: code = 4'd4;
        6'h22, 6'h23: code = 4'd5;
        6'h18: code = 4'd6;
        6'h2A: code = 4'd7;
        6'h02: begin code = 4'd8; shift = 1'b1; end
        6'h00: begin code = 4'd9; shift = 1'b1; end
        6'h03: begin code = 4'hA; shift = 1'b1; end
        default: legal = 1'b0;
      endcase
      6'h01: begin br = 1'b1; code = bus.rt_addr[0] ? 4'hD : 4'hB; legal = bus.rt_addr[4:1] == 4'd0; end
      6'h06: begin br = 1'b1; code = 4'hC; end
      6'h07: begin br = 1'b1; code = 4'hE; end
      6'h08: begin use_imm = 1'b1; sx = 1'b1; code = 4'd4; end
      6'h0A: begin use_imm = 1'b1; sx = 1'b1; code = 4'd7; end
      6'h0C: begin use_imm = 1'b1; code = 4'd0; end
      6'h0D: begin use_imm = 1'b1; code = 4'd1; end
      6'h0E: begin use_imm = 1'b1; code = 4'd3; end
      default: legal = 1'b0;
    endcase
  end
  assign imm_x = {{(DATA_WIDTH-16){sx & bus.imm[15]}}, bus.imm};
  assign b = br ? rs_v : (use_imm ? imm_x : rt_v);
  assign nxt = '{d: {(shift | br) ? {DATA_WIDTH{1'b0}} : rs_v, b},
                 c: CTRL_WIDTH'(code),
                 s: shift ? bus.shamt_in : '0};
  assign acc = bus.in_valid & in_ready_q & ~bus.flush;
  assign push = acc & legal;
  assign drain = main_v_q & bus.out_ready;
  // skid only fills while main is stuck; a draining main takes the skid entry first
  always_comb begin
    main_d = main_q;
    main_v_d = main_v_q;
    skid_d = skid_q;
    skid_v_d = skid_v_q;
    if (bus.flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q || drain) begin
      main_v_d = skid_v_q | push;
      main_d = skid_v_q ? skid_q : (push ? nxt : main_q);
      skid_v_d = 1'b0;
    end else if (push) begin
      skid_v_d = 1'b1;
      skid_d = nxt;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      in_ready_q <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      in_ready_q <= ~skid_v_d;
      illegal_q <= acc & ~legal;
    end
  assign bus.in_ready = in_ready_q;
  assign bus.out_valid = main_v_q;
  assign bus.dataIn = main_q.d;
  assign bus.ctrl = main_q.c;
  assign bus.shamt = main_q.s;
  assign bus.en_n = ~main_v_q;
  assign bus.illegal = illegal_q;
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: scoreboard bench for alu_issue with a table-driven reference decoder
module tb_alu_issue;
  logic clk, rst_n;
  int pass_cnt = 0, total_cnt = 0;
  logic [73:0] q[$];
  logic [73:0] e;
  bit ok, ill_exp = 0, rdy;
  int n;
  int rf[13] = '{'h24, 'h25, 'h27, 'h26, 'h20, 'h21, 'h22, 'h23, 'h18, 'h2A, 'h02, 'h00, 'h03};
  int rc[13] = '{0, 1, 2, 3, 4, 4, 5, 5, 6, 7, 8, 9, 10};
  int io[5] = '{'h08, 'h0A, 'h0C, 'h0D, 'h0E};
  int ic[5] = '{4, 7, 0, 1, 3};
  int ops[12] = '{0, 0, 0, 0, 1, 6, 7, 8, 'hA, 'hC, 'hD, 'hE};

  alu_issue_if #(.DATA_WIDTH(32), .CTRL_WIDTH(5), .SHAMT_WIDTH(5)) bus ();
  alu_issue #(.DATA_WIDTH(32), .CTRL_WIDTH(5), .SHAMT_WIDTH(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] rd(input logic [4:0] a, input logic [31:0] d);
    if (a == 5'd0) return 32'd0;
    if (bus.fwd_we && bus.fwd_addr == a) return bus.fwd_data;
    return d;
  endfunction

  // kind: 0 two-source, 1 shift, 2 signed imm, 3 unsigned imm, 4 branch compare
  function automatic void model(output logic [73:0] ex, output bit legal);
    int code = 0, kind = 0;
    logic [31:0] a, bb, rsv, rtv;
    legal = 0;
    if (bus.opcode == 6'd0) begin
      for (int i = 0; i < 13; i++)
        if (bus.funct == rf[i][5:0]) begin legal = 1; code = rc[i]; kind = (code >= 8) ? 1 : 0; end
    end else if (bus.opcode == 6'd1 && bus.rt_addr < 5'd2) begin
      legal = 1; kind = 4; code = (bus.rt_addr == 5'd1) ? 13 : 11;
    end else if (bus.opcode == 6'd6 || bus.opcode == 6'd7) begin
      legal = 1; kind = 4; code = (bus.opcode == 6'd6) ? 12 : 14;
    end else begin
      for (int i = 0; i < 5; i++)
        if (bus.opcode == io[i][5:0]) begin legal = 1; code = ic[i]; kind = (i < 2) ? 2 : 3; end
    end
    rsv = rd(bus.rs_addr, bus.rs_data);
    rtv = rd(bus.rt_addr, bus.rt_data);
    a = rsv;
    bb = rtv;
    if (kind == 1) a = 0;
    if (kind == 2) bb = 32'($signed(bus.imm));
    if (kind == 3) bb = {16'd0, bus.imm};
    if (kind == 4) begin a = 0; bb = rsv; end
    ex = {a, bb, 5'(code), kind == 1 ? bus.shamt_in : 5'd0};
  endfunction

  always @(negedge rst_n) begin
    q.delete();
    ill_exp = 0;
  end

  always @(negedge clk) if (rst_n) begin
    n = q.size();
    chk("out_valid", 80'(bus.out_valid), 80'(n > 0));
    chk("en_n", 80'(bus.en_n), 80'(n == 0));
    chk("in_ready", 80'(bus.in_ready), 80'(n < 2));
    chk("illegal", 80'(bus.illegal), 80'(ill_exp));
    if (n > 0) chk("issue", 80'({bus.dataIn, bus.ctrl, bus.shamt}), 80'(q[0]));
    ill_exp = 0;
    if (bus.flush) q.delete();
    else begin
      rdy = n < 2;
      if (n > 0 && bus.out_ready) void'(q.pop_front());
      if (bus.in_valid && rdy) begin
        model(e, ok);
        if (ok) q.push_back(e);
        else ill_exp = 1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [31:0] rsd, input logic [31:0] rtd, input logic [15:0] im, input logic [4:0] sh);
    bus.in_valid = 1; bus.opcode = op; bus.funct = fn; bus.rs_addr = rs; bus.rt_addr = rt;
    bus.rs_data = rsd; bus.rt_data = rtd; bus.imm = im; bus.shamt_in = sh;
  endtask

  task automatic send_chk(input string nm, input logic [63:0] d, input logic [4:0] c, input logic [4:0] s);
    cyc();
    bus.in_valid = 0;
    chk({nm, "_data"}, 80'(bus.dataIn), 80'(d));
    chk({nm, "_ctrl"}, 80'(bus.ctrl), 80'(c));
    chk({nm, "_shamt"}, 80'(bus.shamt), 80'(s));
    chk({nm, "_valid"}, 80'(bus.out_valid), 80'(1));
    cyc();
  endtask

  initial begin
    rst_n = 1;
    bus.in_valid = 0; bus.opcode = 0; bus.funct = 0; bus.rs_addr = 0; bus.rt_addr = 0;
    bus.rs_data = 0; bus.rt_data = 0; bus.imm = 0; bus.shamt_in = 0;
    bus.fwd_we = 0; bus.fwd_addr = 0; bus.fwd_data = 0; bus.flush = 0; bus.out_ready = 1;
    #1 rst_n = 0;
    #2;
    chk("rst_out_valid", 80'(bus.out_valid), 80'(0));
    chk("rst_en_n", 80'(bus.en_n), 80'(1));
    chk("rst_in_ready", 80'(bus.in_ready), 80'(1));
    chk("rst_illegal", 80'(bus.illegal), 80'(0));
    chk("rst_out", 80'({bus.dataIn, bus.ctrl, bus.shamt}), 80'(0));
    repeat (2) cyc();
    rst_n = 1;
    cyc();
    set_op(6'h00, 6'h20, 5'd1, 5'd2, 32'd5, 32'd7, 16'd0, 5'd0);
    send_chk("add", 64'h0000000500000007, 5'd4, 5'd0);
    set_op(6'h08, 6'h00, 5'd1, 5'd2, 32'd3, 32'd0, 16'hFFFF, 5'd0);
    send_chk("addi", 64'h00000003FFFFFFFF, 5'd4, 5'd0);
    set_op(6'h0D, 6'h00, 5'd1, 5'd2, 32'd3, 32'd0, 16'hFFFF, 5'd0);
    send_chk("ori", 64'h000000030000FFFF, 5'd1, 5'd0);
    set_op(6'h00, 6'h02, 5'd1, 5'd2, 32'd0, 32'hC0000001, 16'd0, 5'd1);
    send_chk("srl", 64'h00000000C0000001, 5'd8, 5'd1);
    bus.fwd_we = 1; bus.fwd_addr = 5'd4; bus.fwd_data = 32'd9;
    set_op(6'h00, 6'h20, 5'd4, 5'd2, 32'd1, 32'd2, 16'd0, 5'd0);
    send_chk("fwd", 64'h0000000900000002, 5'd4, 5'd0);
    set_op(6'h00, 6'h20, 5'd0, 5'd2, 32'd1, 32'd2, 16'd0, 5'd0);
    send_chk("r0", 64'h0000000000000002, 5'd4, 5'd0);
    bus.fwd_we = 0;
    bus.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      set_op(6'h00, 6'h25, 5'd1, 5'd2, 32'(i + 10), 32'(i + 20), 16'd0, 5'd0);
      cyc();
      if (i > 0) chk("full_in_ready", 80'(bus.in_ready), 80'(0));
    end
    bus.in_valid = 0;
    repeat (3) cyc();
    bus.out_ready = 1;
    repeat (3) cyc();
    set_op(6'h3F, 6'h00, 5'd1, 5'd2, 32'd1, 32'd2, 16'd0, 5'd0);
    cyc();
    bus.in_valid = 0;
    chk("ill_pulse", 80'(bus.illegal), 80'(1));
    chk("ill_noissue", 80'(bus.out_valid), 80'(0));
    cyc();
    chk("ill_once", 80'(bus.illegal), 80'(0));
    bus.out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      set_op(6'h0E, 6'h00, 5'd3, 5'd2, 32'(i), 32'd0, 16'h1234, 5'd0);
      cyc();
    end
    set_op(6'h3F, 6'h00, 5'd1, 5'd2, 32'd1, 32'd2, 16'd0, 5'd0);
    bus.flush = 1;
    cyc();
    bus.flush = 0;
    bus.in_valid = 0;
    chk("flush_valid", 80'(bus.out_valid), 80'(0));
    chk("flush_ready", 80'(bus.in_ready), 80'(1));
    chk("flush_ill", 80'(bus.illegal), 80'(0));
    for (int i = 0; i < 2; i++) begin
      set_op(6'h07, 6'h00, 5'd3, 5'd2, 32'(i + 5), 32'd0, 16'd0, 5'd0);
      cyc();
    end
    bus.in_valid = 0;
    rst_n = 0;
    #1;
    chk("arst_valid", 80'(bus.out_valid), 80'(0));
    chk("arst_ready", 80'(bus.in_ready), 80'(1));
    #1 rst_n = 1;
    bus.out_ready = 1;
    cyc();
    chk("arst_noissue", 80'(bus.out_valid), 80'(0));
    for (int i = 0; i < 3000; i++) begin
      set_op(($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'(ops[$urandom_range(0, 11)]),
             ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'(rf[$urandom_range(0, 12)]),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom, $urandom,
             16'($urandom), 5'($urandom));
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.fwd_we = 1'($urandom);
      bus.fwd_addr = 5'($urandom_range(0, 3));
      bus.fwd_data = $urandom;
      bus.out_ready = ($urandom_range(0, 9) < 6);
      bus.flush = ($urandom_range(0, 39) == 0);
      cyc();
    end
    bus.in_valid = 0; bus.flush = 0; bus.out_ready = 1;
    repeat (5) cyc();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
